lsu_mem_if: RTL and testbench

- Load/store unit between the core's data-memory outputs (ALU address, store data, funct3, write enable) and a variable-latency data memory.
- Adds byte and halfword access (lb/lbu/lh/lhu/sb/sh) on top of lw/sw, with byte-lane steering and sign/zero extension.
- Uses a req/ack memory handshake and raises a stall to the core until each access completes.
- Detects misaligned accesses, unsupported funct3 codes and memory timeouts, and reports them as errors.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_mem_if.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_if.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] be_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store-side enables/replication and legality,
// load-side lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    be_t         be_c;
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    always_comb begin
        be_c       = 4'b0000;
        wdata      = req_wdata;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (req_funct3)
            F3_B, F3_BU: begin
                be_c  = 4'b0001 << req_off;
                wdata = {4{req_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c       = 4'b0011 << req_off;
                wdata      = {2{req_wdata[15:0]}};
                misaligned = req_off[0];
            end
            F3_W: begin
                be_c       = 4'b1111;
                misaligned = |req_off;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU))
            illegal = 1'b1;
    end

    assign be = be_c;

    always_comb begin
        byte_l = rdata[8*ld_off +: 8];
        half_l = rdata[16*ld_off[1] +: 16];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_l[7]}}, byte_l};
            F3_BU:   ld_data = {24'h0, byte_l};
            F3_H:    ld_data = {{16{half_l[15]}}, half_l};
            F3_HU:   ld_data = {16'h0, half_l};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit front end: accepts one core access at a time, runs a
// req/ack transaction to data memory with a timeout, and returns one response.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [3:0]         be_q, be_d;
    logic [2:0]         f3_q, f3_d;
    logic               we_q, we_d;
    logic               err_q, err_d;

    logic [3:0]         al_be;
    logic [31:0]        al_wdata;
    logic [31:0]        al_ld_data;
    logic               al_mis;
    logic               al_ill;

    // Store path sees the live request; load path sees the registered access.
    lsu_align u_align (
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .misaligned (al_mis),
        .illegal    (al_ill),
        .ld_funct3  (f3_q),
        .ld_off     (addr_q[1:0]),
        .rdata      (mem_rdata),
        .ld_data    (al_ld_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        we_d       = we_q;
        err_d      = err_q;
        stall      = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req_valid;
                cnt_d = '0;
                if (req_valid) begin
                    rdata_d = '0;
                    if (al_ill || al_mis) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = req_addr;
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        we_d    = req_we;
                        f3_d    = req_funct3;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : al_ld_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign mem_we     = mem_req & we_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_q;
    assign mem_be     = be_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Scoreboard bench for lsu_mem_if: expected responses are queued as requests
// are issued and compared when resp_valid fires.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb_q[$];

    int          mem_delay = 0;
    logic [31:0] mem_data = 32'h0;
    int          acc_cnt = 0;
    logic        force_ack = 1'b0;

    int          last_reqs;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;
    logic        addr_stable;

    lsu_mem_if #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: acks on the mem_delay-th cycle of a request (0 = never).
    always @(negedge clk) begin
        if (mem_req && mem_delay != 0) begin
            acc_cnt++;
            mem_ack = (acc_cnt == mem_delay) | force_ack;
        end else begin
            acc_cnt = 0;
            mem_ack = force_ack;
        end
        mem_rdata = mem_data;
    end

    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e[32:1]);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e[0]});
            end
        end
    end

    // Called just after a posedge; returns just after the posedge ending RESP.
    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int delay,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_stall, input int exp_lat);
        int  n;
        int  stalls;
        bit  got;
        n = 0; stalls = 0; got = 0;
        last_reqs = 0; addr_stable = 1'b1;
        mem_delay = delay;
        mem_data  = rd;
        sb_q.push_back({exp_rd, exp_err});
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (stall) stalls++;
            if (mem_req) begin
                last_reqs++;
                if (last_reqs == 1) last_addr = mem_addr;
                else if (mem_addr !== last_addr) addr_stable = 1'b0;
                last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
            end
            if (resp_valid) got = 1;
        end
        if (!got) chk({name, "_no_resp"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({name, "_lat"}, n, exp_lat);
        chk({name, "_stall"}, stalls, exp_stall);
    endtask

    initial begin
        #12;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        run("lb62", 0, F3_B, 32'h62, 32'h0, 32'h80FF1234, 1, 32'hFFFFFFFF, 0, 2, 3);
        chk("lb62_be", {28'b0, last_be}, 32'b0100);
        chk("lb62_reqs", last_reqs, 32'd1);
        run("lbu62", 0, F3_BU, 32'h62, 32'h0, 32'h80FF1234, 1, 32'h000000FF, 0, 2, 3);
        run("lhu62", 0, F3_HU, 32'h62, 32'h0, 32'h80FF1234, 1, 32'h000080FF, 0, 2, 3);
        run("lh62", 0, F3_H, 32'h62, 32'h0, 32'h80FF1234, 1, 32'hFFFF80FF, 0, 2, 3);
        chk("lh62_be", {28'b0, last_be}, 32'b1100);
        run("lb61", 0, F3_B, 32'h61, 32'h0, 32'h80FF1234, 2, 32'h00000012, 0, 3, 4);
        run("lh60", 0, F3_H, 32'h60, 32'h0, 32'h80FF9234, 1, 32'hFFFF9234, 0, 2, 3);

        run("sh66", 1, F3_H, 32'h66, 32'hDEADBEEF, 32'h12345678, 1, 32'h0, 0, 2, 3);
        chk("sh66_be", {28'b0, last_be}, 32'b1100);
        chk("sh66_wdata", last_wdata, 32'hBEEFBEEF);
        chk("sh66_addr", last_addr, 32'h64);
        chk("sh66_we", {31'b0, last_we}, 32'd1);
        run("sb63", 1, F3_B, 32'h63, 32'h0000005A, 32'h0, 1, 32'h0, 0, 2, 3);
        chk("sb63_be", {28'b0, last_be}, 32'b1000);
        chk("sb63_wdata", last_wdata, 32'h5A5A5A5A);

        run("lw64", 0, F3_W, 32'h64, 32'h0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 0, 4, 5);
        chk("lw64_reqs", last_reqs, 32'd3);
        chk("lw64_stable", {31'b0, addr_stable}, 32'd1);
        chk("lw64_addr", last_addr, 32'h64);
        chk("lw64_we", {31'b0, last_we}, 32'd0);

        run("lh61_mis", 0, F3_H, 32'h61, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 1, 1, 2);
        chk("lh61_reqs", last_reqs, 32'd0);
        run("sw62_mis", 1, F3_W, 32'h62, 32'h1111, 32'hFFFFFFFF, 1, 32'h0, 1, 1, 2);
        chk("sw62_reqs", last_reqs, 32'd0);
        run("f3_011", 0, 3'b011, 32'h60, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 1, 1, 2);
        chk("f3_011_reqs", last_reqs, 32'd0);
        run("sbu_ill", 1, F3_BU, 32'h60, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 1, 1, 2);
        chk("sbu_reqs", last_reqs, 32'd0);

        run("lw70_edge", 0, F3_W, 32'h70, 32'h0, 32'h11223344, 4, 32'h11223344, 0, 5, 6);
        chk("lw70_reqs", last_reqs, 32'd4);
        run("lw74_tmo", 0, F3_W, 32'h74, 32'h0, 32'h55667788, 0, 32'h0, 1, 5, 6);
        chk("lw74_reqs", last_reqs, 32'd4);

        // Reset while an access is outstanding, then an ack that must be ignored.
        mem_delay = 0;
        req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40; req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ra_req_before", {31'b0, mem_req}, 32'd1);
        #2;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("ra_req_async", {31'b0, mem_req}, 32'd0);
        chk("ra_stall_async", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ra_no_resp", {31'b0, resp_valid}, 32'd0);
            chk("ra_no_req", {31'b0, mem_req}, 32'd0);
        end
        force_ack = 1'b0;
        @(posedge clk); #1;

        run("sw80", 1, F3_W, 32'h80, 32'hA5A5_0F0F, 32'h0, 1, 32'h0, 0, 2, 3);
        chk("sw80_wdata", last_wdata, 32'hA5A50F0F);
        chk("sw80_be", {28'b0, last_be}, 32'b1111);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
